// File: rtl/dram_bank_scheduler_pkg.sv
// Shared encodings for the DRAM bank scheduler: bank geometry, command codes, FSM states.
// Latency: n/a (definitions only). Backpressure: n/a.
// Imported by the scheduler top and its round-robin arbiter.
package dram_bank_scheduler_pkg;

    localparam int NUM_BANKS = 8;
    localparam int BANK_W    = 3;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_ACT = 2'b01;
    localparam logic [1:0] CMD_PRE = 2'b10;
    localparam logic [1:0] CMD_REF = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACT    = 3'd1,
        ST_ACCESS = 3'd2,
        ST_PRE    = 3'd3,
        ST_REF    = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dram_rr_arbiter8.sv
// Round-robin pick among eight bank requests, searching upward from last+1 with wrap.
// Latency: purely combinational. Backpressure: none; valid is simply |req.
// Caller decides when the winner is consumed and updates last.
module dram_rr_arbiter8
    import dram_bank_scheduler_pkg::*;
(
    input  logic [NUM_BANKS-1:0] req,
    input  logic [BANK_W-1:0]    last,
    output logic [BANK_W-1:0]    winner,
    output logic                 valid
);

    logic [BANK_W-1:0] idx;

    // Walk from the farthest offset to the nearest so the nearest set bit wins.
    always_comb begin
        winner = '0;
        valid  = |req;
        idx    = '0;
        for (int i = NUM_BANKS; i >= 1; i--) begin
            idx = last + BANK_W'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dram_bank_scheduler.sv
// Serves eight DRAM banks round-robin through ACT/ACCESS/PRE, with periodic refresh taking priority.
// Latency: gnt T_ACT+1 cycles after req is sampled in IDLE; service period T_ACT+T_PRE+2 cycles.
// Backpressure: req is a held level, sampled only in IDLE; gnt pulse is the acknowledge.
module dram_bank_scheduler
    import dram_bank_scheduler_pkg::*;
#(
    parameter int T_ACT            = 3,
    parameter int T_PRE            = 2,
    parameter int T_RFC            = 8,
    parameter int REFRESH_INTERVAL = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BANKS-1:0] req,
    output logic [NUM_BANKS-1:0] gnt,
    output logic [BANK_W-1:0]    bank_sel,
    output logic                 bank_en,
    output logic [1:0]           cmd,
    output logic                 busy,
    output logic                 ref_due
);

    localparam int T_MAX = max3(T_ACT, T_PRE, T_RFC);
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int RW    = $clog2(REFRESH_INTERVAL);

    localparam logic [CW-1:0] ACT_LAST     = CW'(T_ACT - 1);
    localparam logic [CW-1:0] PRE_LAST     = CW'(T_PRE - 1);
    localparam logic [CW-1:0] RFC_LAST     = CW'(T_RFC - 1);
    localparam logic [RW-1:0] RCNT_RELOAD  = RW'(REFRESH_INTERVAL - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [BANK_W-1:0] last_q, last_d;
    logic              ref_due_q, ref_due_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic              ref_expire;
    logic [BANK_W-1:0] arb_winner;
    logic              arb_valid;

    dram_rr_arbiter8 u_arb (
        .req    (req),
        .last   (last_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bank_d     = bank_q;
        last_d     = last_q;
        ref_due_d  = ref_due_q;
        ref_expire = (rcnt_q == '0);
        rcnt_d     = ref_expire ? RCNT_RELOAD : rcnt_q - 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ref_due_q) begin
                    state_d   = ST_REF;
                    ref_due_d = 1'b0;
                end else if (arb_valid) begin
                    state_d = ST_ACT;
                    bank_d  = arb_winner;
                    last_d  = arb_winner;
                end
            end
            ST_ACT: begin
                if (cnt_q == ACT_LAST) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_PRE;
                cnt_d   = '0;
            end
            ST_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REF: begin
                if (cnt_q == RFC_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A fresh expiry overrides the clear on REF entry; a second one while pending is absorbed.
        if (ref_expire) begin
            ref_due_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bank_q    <= '0;
            last_q    <= BANK_W'(NUM_BANKS - 1);
            ref_due_q <= 1'b0;
            rcnt_q    <= RCNT_RELOAD;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bank_q    <= bank_d;
            last_q    <= last_d;
            ref_due_q <= ref_due_d;
            rcnt_q    <= rcnt_d;
        end
    end

    always_comb begin
        gnt      = '0;
        cmd      = CMD_NOP;
        bank_en  = 1'b0;
        bank_sel = bank_q;
        busy     = (state_q != ST_IDLE);
        ref_due  = ref_due_q;
        unique case (state_q)
            ST_ACT: begin
                bank_en = 1'b1;
                if (cnt_q == '0) cmd = CMD_ACT;
            end
            ST_ACCESS: begin
                bank_en = 1'b1;
                gnt     = NUM_BANKS'(1) << bank_q;
            end
            ST_PRE: begin
                bank_en = 1'b1;
                if (cnt_q == '0) cmd = CMD_PRE;
            end
            ST_REF: begin
                if (cnt_q == '0) cmd = CMD_REF;
            end
            default: begin
                cmd = CMD_NOP;
            end
        endcase
    end

endmodule

// File: tb/tb_dram_bank_scheduler.sv
// Bench for dram_bank_scheduler: directed request patterns then random load, checked each cycle
// against a schedule-queue model of bank service and refresh.
module tb_dram_bank_scheduler;

    localparam int T_ACT = 3;
    localparam int T_PRE = 2;
    localparam int T_RFC = 8;
    localparam int RI    = 1024;
    localparam int NCYC  = 6000;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] bank_sel;
    logic       bank_en;
    logic [1:0] cmd;
    logic       busy;
    logic       ref_due;

    always #5 clk = ~clk;

    dram_bank_scheduler #(
        .T_ACT            (T_ACT),
        .T_PRE            (T_PRE),
        .T_RFC            (T_RFC),
        .REFRESH_INTERVAL (RI)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .bank_sel (bank_sel),
        .bank_en  (bank_en),
        .cmd      (cmd),
        .busy     (busy),
        .ref_due  (ref_due)
    );

    // One entry per expected busy cycle; an empty queue means the scheduler idles.
    typedef struct {
        logic [7:0] gnt;
        logic       en;
        logic [1:0] cmd;
        bit         is_act;
    } slot_t;

    slot_t sched[$];
    bit    pend;
    int    nedge;
    int    mlast;
    int    mbank;
    int    checks   = 0;
    int    failures = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        pend  = 1'b0;
        nedge = 0;
        mlast = 7;
        mbank = 0;
    endtask

    task automatic push_slot(input logic [7:0] g, input logic en, input logic [1:0] c, input bit a);
        slot_t s;
        s.gnt    = g;
        s.en     = en;
        s.cmd    = c;
        s.is_act = a;
        sched.push_back(s);
    endtask

    task automatic model_edge();
        int w;
        if (sched.size() == 0) begin
            if (pend) begin
                pend = 1'b0;
                for (int i = 0; i < T_RFC; i++) push_slot(8'h00, 1'b0, (i == 0) ? 2'b11 : 2'b00, 1'b0);
            end else if (req != 8'h00) begin
                w = -1;
                for (int off = 1; off <= 8 && w < 0; off++) begin
                    if (req[(mlast + off) % 8]) w = (mlast + off) % 8;
                end
                mlast = w;
                mbank = w;
                for (int i = 0; i < T_ACT; i++) push_slot(8'h00, 1'b1, (i == 0) ? 2'b01 : 2'b00, 1'b1);
                push_slot(8'(1 << w), 1'b1, 2'b00, 1'b0);
                for (int i = 0; i < T_PRE; i++) push_slot(8'h00, 1'b1, (i == 0) ? 2'b10 : 2'b00, 1'b0);
            end
        end else begin
            void'(sched.pop_front());
        end
        nedge++;
        if (nedge % RI == 0) pend = 1'b1;
    endtask

    task automatic check_outputs(output logic [7:0] granted);
        slot_t e;
        bit    b;
        b = (sched.size() != 0);
        if (b) begin
            e = sched[0];
        end else begin
            e.gnt = 8'h00; e.en = 1'b0; e.cmd = 2'b00; e.is_act = 1'b0;
        end
        check_val("gnt", gnt, e.gnt);
        check_val("gnt_count", 8'($countones(gnt)), 8'($countones(e.gnt)));
        check_val("bank_sel", {5'd0, bank_sel}, 8'(mbank));
        check_val("bank_en", {7'd0, bank_en}, {7'd0, e.en});
        check_val("cmd", {6'd0, cmd}, {6'd0, e.cmd});
        check_val("busy", {7'd0, busy}, {7'd0, b});
        check_val("ref_due", {7'd0, ref_due}, {7'd0, pend});
        granted = e.gnt;
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_gnt"}, gnt, 8'h00);
        check_val({pfx, "_bank_sel"}, {5'd0, bank_sel}, 8'h00);
        check_val({pfx, "_bank_en"}, {7'd0, bank_en}, 8'h00);
        check_val({pfx, "_cmd"}, {6'd0, cmd}, 8'h00);
        check_val({pfx, "_busy"}, {7'd0, busy}, 8'h00);
        check_val({pfx, "_ref_due"}, {7'd0, ref_due}, 8'h00);
    endtask

    // Reset asserted between edges: outputs must clear before any clock edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 check_reset_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive_req(input int cyc);
        if (cyc == 0) begin
            req = 8'h04;
        end else if (cyc >= 20 && cyc < 100) begin
            req = 8'hFF;
        end else if (cyc >= 100 && cyc < 180) begin
            req = 8'h81;
        end else if (cyc >= 180) begin
            if ($urandom_range(0, 3) == 0) req = req | 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) req = req & ~8'(1 << $urandom_range(0, 7));
        end
    endtask

    initial begin
        logic [7:0] granted;
        bit         act_rst_done;
        act_rst_done = 1'b0;
        rst = 1'b1;
        req = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            drive_req(cyc);
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs(granted);
            req = req & ~granted;
            if (cyc >= 140 && !act_rst_done && sched.size() != 0 && sched[0].is_act) begin
                act_rst_done = 1'b1;
                pulse_reset();
            end else if (cyc >= 3000 && cyc < 3600 && $urandom_range(0, 149) == 0) begin
                pulse_reset();
            end
        end

        check_val("act_reset_injected", {7'd0, act_rst_done}, 8'h01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
